// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_read_arbiter
// Purpose  : Shares one AXI read port between i-cache and d-cache refills.
//            The grant is held for the whole burst and RVALID is steered to
//            the owner. D-cache refills wait for its outstanding flush writes.
//            Optional macro MEM_ARB_ROUND_ROBIN_EN: tie-break on last owner.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int LEN_WIDTH  = 4,
  parameter int MAX_WR_OUT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_arvalid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [LEN_WIDTH-1:0]  i_arlen,
  output logic                  i_arready,
  output logic                  i_rvalid,
  input  logic                  d_arvalid,
  input  logic [ADDR_WIDTH-1:0] d_araddr,
  input  logic [LEN_WIDTH-1:0]  d_arlen,
  output logic                  d_arready,
  output logic                  d_rvalid,
  output logic                  m_arvalid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [LEN_WIDTH-1:0]  m_arlen,
  output logic [3:0]            m_arid,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic                  aw_fire,
  input  logic                  b_fire
);

  localparam int c_WR_WIDTH = $clog2(MAX_WR_OUT + 1);
  localparam logic [c_WR_WIDTH-1:0] c_WR_MAX = c_WR_WIDTH'(MAX_WR_OUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_len;
  logic                    r_owner_d;
  logic                    r_last_d;
  logic [LEN_WIDTH-1:0]    r_beat_cnt;
  logic [c_WR_WIDTH-1:0]   r_wr_out;
  logic                    w_i_elig;
  logic                    w_d_elig;
  logic                    w_pick_d;
  logic                    w_grant;

  assign w_i_elig = i_arvalid;
  assign w_d_elig = d_arvalid & (r_wr_out == '0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie the requester that did not own the previous burst wins.
  assign w_pick_d = w_d_elig & (~w_i_elig | ~r_last_d);
`else
  assign w_pick_d = w_d_elig;
`endif

  assign m_araddr = r_addr;
  assign m_arlen  = r_len;
  assign m_arid   = {3'b000, r_owner_d};

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    m_arvalid = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_i_elig | w_d_elig) begin
          w_grant = 1'b1;
          w_next  = S_ADDR;
        end
      end
      S_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          i_arready = ~r_owner_d;
          d_arready = r_owner_d;
          w_next    = S_DATA;
        end
      end
      S_DATA: begin
        i_rvalid = m_rvalid & ~r_owner_d;
        d_rvalid = m_rvalid & r_owner_d;
        if (m_rvalid && (r_beat_cnt <= LEN_WIDTH'(1))) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_owner_d  <= 1'b0;
      r_last_d   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner_d <= w_pick_d;
        r_last_d  <= w_pick_d;
        r_addr    <= w_pick_d ? d_araddr : i_araddr;
        r_len     <= w_pick_d ? d_arlen : i_arlen;
      end
      // A zero length is treated as a single beat.
      if ((r_state == S_ADDR) && m_arready) begin
        r_beat_cnt <= (r_len == '0) ? LEN_WIDTH'(1) : r_len;
      end else if ((r_state == S_DATA) && m_rvalid) begin
        r_beat_cnt <= r_beat_cnt - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_out <= '0;
    end else if (aw_fire && !b_fire && (r_wr_out != c_WR_MAX)) begin
      r_wr_out <= r_wr_out + c_WR_WIDTH'(1);
    end else if (b_fire && !aw_fire && (r_wr_out != '0)) begin
      r_wr_out <= r_wr_out - c_WR_WIDTH'(1);
    end
  end

  a_rvalid_only_in_data: assert property (
    @(posedge clk) disable iff (rst) m_rvalid |-> (r_state == S_DATA)
  );

endmodule
`default_nettype wire
